// File: rtl/pixel_array_rowscan_pkg.sv
// Shared types and helpers for the row-scanned pixel array.
// Holds FSM state codes, default widths and the saturating accumulate.
package pixel_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_e;

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_ERASE   = ST_ERASE;
    localparam logic [2:0] S_EXPOSE  = ST_EXPOSE;
    localparam logic [2:0] S_CONVERT = ST_CONVERT;
    localparam logic [2:0] S_READ    = ST_READ;

    localparam int ROWS_DEF   = 4;
    localparam int COLS_DEF   = 4;
    localparam int DATA_W_DEF = 8;
    localparam int LVL_W_DEF  = 4;
    localparam int EXP_W_DEF  = 8;

    // Add and clamp to maxv; width-agnostic so every cell size can use it.
    function automatic int unsigned sat_add(
        input int unsigned acc,
        input int unsigned lvl,
        input int unsigned maxv
    );
        int unsigned sum;
        sum = acc + lvl;
        return (sum > maxv) ? maxv : sum;
    endfunction

endpackage

// File: rtl/pixel_array_rowscan_if.sv
// Row readout bus: one COLS-wide row of codes per valid/ready transfer.
// master drives valid/row/data and samples ready; slave is the consumer.
interface pixel_array_rowscan_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                   out_valid;
    logic                   out_ready;
    logic [RW-1:0]          out_row;
    logic [COLS*DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_row,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_row,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pixel_array_rowscan_cell.sv
// One pixel: saturating exposure accumulator plus ramp comparator/latch.
// Ports: clk, reset, erase_i, expose_en_i, convert_en_i, ramp_i, light_i, code_o.
module pixel_cell
    import pixel_array_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LVL_W  = LVL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase_i,
    input  logic              expose_en_i,
    input  logic              convert_en_i,
    input  logic [DATA_W-1:0] ramp_i,
    input  logic [LVL_W-1:0]  light_i,
    output logic [DATA_W-1:0] code_o
);
    localparam int unsigned MAXV = (1 << DATA_W) - 1;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic              done_q, done_d;

    always_comb begin
        acc_d  = acc_q;
        code_d = code_q;
        done_d = done_q;
        if (erase_i) begin
            acc_d  = '0;
            code_d = '0;
            done_d = 1'b0;
        end else if (expose_en_i) begin
            acc_d = DATA_W'(sat_add(32'(acc_q), 32'(light_i), MAXV));
        end else if (convert_en_i && !done_q && (ramp_i >= acc_q)) begin
            // First ramp step at or above the charge wins; later steps ignored.
            code_d = ramp_i;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            code_q <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            code_q <= code_d;
            done_q <= done_d;
        end
    end

    assign code_o = code_q;
endmodule

// File: rtl/pixel_array_rowscan.sv
// ROWS x COLS pixel array with frame sequencer and row readout.
// Ports: clk, reset, start, expose_len, light in; busy, frame_done out; out bus (master).
module pixel_array_rowscan
    import pixel_array_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LVL_W  = LVL_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [EXP_W-1:0]          expose_len,
    input  logic [ROWS*COLS*LVL_W-1:0] light,
    output logic                      busy,
    output logic                      frame_done,
    pixel_array_rowscan_if.master     out
);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROWB = COLS * DATA_W;

    logic [2:0]        state_q, state_d;
    logic [EXP_W-1:0]  e_q, e_d;
    logic [EXP_W-1:0]  exp_cnt_q, exp_cnt_d;
    logic [DATA_W-1:0] ramp_q, ramp_d;
    logic [RW-1:0]     row_q, row_d;
    logic              fd_q, fd_d;

    logic [ROWS*ROWB-1:0] codes;

    logic erase, expose_en, convert_en;
    assign erase      = (state_q == S_ERASE);
    assign expose_en  = (state_q == S_EXPOSE);
    assign convert_en = (state_q == S_CONVERT);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pixel_cell #(
                .DATA_W (DATA_W),
                .LVL_W  (LVL_W)
            ) u_cell (
                .clk          (clk),
                .reset        (reset),
                .erase_i      (erase),
                .expose_en_i  (expose_en),
                .convert_en_i (convert_en),
                .ramp_i       (ramp_q),
                .light_i      (light[(r*COLS+c)*LVL_W +: LVL_W]),
                .code_o       (codes[r*ROWB + c*DATA_W +: DATA_W])
            );
        end
    end

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        exp_cnt_d = exp_cnt_q;
        ramp_d    = ramp_q;
        row_d     = row_q;
        fd_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    e_d     = expose_len;
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                exp_cnt_d = e_q;
                ramp_d    = '0;
                state_d   = (e_q != '0) ? S_EXPOSE : S_CONVERT;
            end
            S_EXPOSE: begin
                exp_cnt_d = exp_cnt_q - 1'b1;
                if (exp_cnt_q == EXP_W'(1)) state_d = S_CONVERT;
            end
            S_CONVERT: begin
                // Ramp wraps to 0 on its last step, leaving it clean for next frame.
                ramp_d = ramp_q + 1'b1;
                row_d  = '0;
                if (ramp_q == '1) state_d = S_READ;
            end
            S_READ: begin
                if (out.out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        fd_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            e_q       <= '0;
            exp_cnt_q <= '0;
            ramp_q    <= '0;
            row_q     <= '0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            exp_cnt_q <= exp_cnt_d;
            ramp_q    <= ramp_d;
            row_q     <= row_d;
            fd_q      <= fd_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign frame_done    = fd_q;
    assign out.out_valid = (state_q == S_READ);
    assign out.out_row   = row_q;
    assign out.out_data  = out.out_valid ? codes[int'(row_q)*ROWB +: ROWB] : '0;
endmodule
